// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand fetch stage: 32x32 register file with write-through bypass feeding a one-entry ready/valid output register
module alu_operand_stage #(
    parameter logic IMM_SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [15:0] imm,
    input  logic        use_imm,
    input  logic [3:0]  alu_op,
    input  logic [4:0]  dest_addr,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  Selector_op,
    output logic [4:0]  out_dest,
    output logic        illegal_op,
    output logic [15:0] issue_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [3:0] OP_ZERO = 4'b1000;

    state_t      state_q;
    logic [31:0] regs_q [32];

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  sel_q;
    logic [4:0]  dest_q;
    logic        illegal_q;
    logic [15:0] count_q;

    logic        wr_fire;
    logic        accept;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [31:0] a_d;
    logic [31:0] b_d;
    logic [3:0]  sel_d;
    logic        illegal_d;

    assign wr_fire = wr_en && (wr_addr != 5'd0);

    // in_ready is forced low during reset so nothing is accepted while the stage is cleared
    assign in_ready = rst_n && ((state_q == EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        rs_data = 32'd0;
        if (rs_addr != 5'd0) begin
            if (wr_fire && (wr_addr == rs_addr)) begin
                rs_data = wr_data;
            end else begin
                rs_data = regs_q[rs_addr];
            end
        end
    end

    always_comb begin
        rt_data = 32'd0;
        if (rt_addr != 5'd0) begin
            if (wr_fire && (wr_addr == rt_addr)) begin
                rt_data = wr_data;
            end else begin
                rt_data = regs_q[rt_addr];
            end
        end
    end

    always_comb begin
        imm_ext   = IMM_SIGNED ? {{16{imm[15]}}, imm} : {16'h0000, imm};
        a_d       = rs_data;
        b_d       = use_imm ? imm_ext : rt_data;
        illegal_d = (alu_op > OP_ZERO);
        sel_d     = illegal_d ? OP_ZERO : alu_op;
    end

    // Entry 0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (wr_fire) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            sel_q     <= 4'd0;
            dest_q    <= 5'd0;
            illegal_q <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (!accept && out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase

            if (accept) begin
                a_q       <= a_d;
                b_q       <= b_d;
                sel_q     <= sel_d;
                dest_q    <= dest_addr;
                illegal_q <= illegal_d;
                count_q   <= count_q + 16'd1;
            end
        end
    end

    assign out_valid   = (state_q == FULL);
    assign A           = a_q;
    assign B           = b_q;
    assign Selector_op = sel_q;
    assign out_dest    = dest_q;
    assign illegal_op  = illegal_q;
    assign issue_count = count_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [15:0] imm;
    logic        use_imm;
    logic [3:0]  alu_op;
    logic [4:0]  dest_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        out_ready;

    logic        in_ready,  in_ready_u;
    logic        out_valid, out_valid_u;
    logic [31:0] a_o, a_u;
    logic [31:0] b_o, b_u;
    logic [3:0]  sel_o, sel_u;
    logic [4:0]  dest_o, dest_u;
    logic        ill_o, ill_u;
    logic [15:0] cnt_o, cnt_u;

    int tests = 0;
    int fails = 0;

    alu_operand_stage #(.IMM_SIGNED(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .use_imm(use_imm),
        .alu_op(alu_op), .dest_addr(dest_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .out_valid(out_valid), .out_ready(out_ready),
        .A(a_o), .B(b_o), .Selector_op(sel_o), .out_dest(dest_o),
        .illegal_op(ill_o), .issue_count(cnt_o)
    );

    alu_operand_stage #(.IMM_SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .use_imm(use_imm),
        .alu_op(alu_op), .dest_addr(dest_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .out_valid(out_valid_u), .out_ready(out_ready),
        .A(a_u), .B(b_u), .Selector_op(sel_u), .out_dest(dest_u),
        .illegal_op(ill_u), .issue_count(cnt_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic ui,
                         input logic [15:0] im, input logic [3:0] op, input logic [4:0] dst);
        in_valid  = 1'b1;
        rs_addr   = rs;
        rt_addr   = rt;
        use_imm   = ui;
        imm       = im;
        alu_op    = op;
        dest_addr = dst;
    endtask

    task automatic write_reg(input logic en, input logic [4:0] addr, input logic [31:0] data);
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        rs_addr = '0; rt_addr = '0; imm = '0; use_imm = 1'b0;
        alu_op = '0; dest_addr = '0;
        write_reg(1'b0, 5'd0, 32'd0);

        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_A", a_o, 32'd0);
        check("rst_count", cnt_o, 16'd0);

        // First edge after release both accepts and writes r5
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(5'd0, 5'd0, 1'b0, 16'h0, 4'b0001, 5'd1);
        write_reg(1'b1, 5'd5, 32'h0000_0007);
        tick();
        check("first_accept_valid", out_valid, 1'b1);
        check("first_accept_count", cnt_o, 16'd1);

        write_reg(1'b0, 5'd0, 32'd0);
        issue(5'd5, 5'd0, 1'b0, 16'h0, 4'b0000, 5'd3);
        tick();
        check("r5_A", a_o, 32'h0000_0007);
        check("r5_B", b_o, 32'd0);
        check("r5_sel", sel_o, 4'b0000);
        check("r5_dest", dest_o, 5'd3);
        check("r5_illegal", ill_o, 1'b0);

        write_reg(1'b1, 5'd9, 32'hDEAD_BEEF);
        issue(5'd9, 5'd5, 1'b0, 16'h0, 4'b0111, 5'd4);
        tick();
        check("bypass_A", a_o, 32'hDEAD_BEEF);
        check("bypass_B", b_o, 32'h0000_0007);
        check("bypass_sel", sel_o, 4'b0111);

        write_reg(1'b1, 5'd0, 32'h0000_1234);
        issue(5'd0, 5'd9, 1'b0, 16'h0, 4'b0101, 5'd4);
        tick();
        check("r0_A", a_o, 32'd0);
        check("r9_B", b_o, 32'hDEAD_BEEF);
        check("count4", cnt_o, 16'd4);

        write_reg(1'b0, 5'd0, 32'd0);
        issue(5'd5, 5'd0, 1'b1, 16'h8001, 4'b0010, 5'd6);
        tick();
        check("imm_signed_B", b_o, 32'hFFFF_8001);
        check("imm_unsigned_B", b_u, 32'h0000_8001);
        check("count5", cnt_o, 16'd5);

        // Stall with a writeback to r5 that must not leak into the held entry
        out_ready = 1'b0;
        issue(5'd9, 5'd0, 1'b0, 16'h0, 4'b0100, 5'd7);
        write_reg(1'b1, 5'd5, 32'h0000_0055);
        #1;
        check("stall_in_ready", in_ready, 1'b0);
        tick();
        write_reg(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        check("stall_valid", out_valid, 1'b1);
        check("stall_A", a_o, 32'h0000_0007);
        check("stall_B", b_o, 32'hFFFF_8001);
        check("stall_sel", sel_o, 4'b0010);
        check("stall_dest", dest_o, 5'd6);
        check("stall_count", cnt_o, 16'd5);
        check("stall_in_ready2", in_ready, 1'b0);

        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        tick();
        check("release_A", a_o, 32'hDEAD_BEEF);
        check("release_sel", sel_o, 4'b0100);
        check("release_dest", dest_o, 5'd7);
        check("release_count", cnt_o, 16'd6);

        issue(5'd5, 5'd0, 1'b0, 16'h0, 4'b1100, 5'd8);
        tick();
        check("illegal_sel", sel_o, 4'b1000);
        check("illegal_flag", ill_o, 1'b1);
        check("illegal_A", a_o, 32'h0000_0055);
        check("count7", cnt_o, 16'd7);

        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 1'b0);
        check("drain_in_ready", in_ready, 1'b1);

        out_ready = 1'b0;
        tick();
        check("idle_valid", out_valid, 1'b0);
        check("idle_count", cnt_o, 16'd7);
        check("idle_sel", sel_o, 4'b1000);

        issue(5'd5, 5'd9, 1'b0, 16'h0, 4'b0011, 5'd2);
        tick();
        check("pre_reset_valid", out_valid, 1'b1);
        check("pre_reset_count", cnt_o, 16'd8);
        in_valid = 1'b0;

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", out_valid, 1'b0);
        check("async_A", a_o, 32'd0);
        check("async_B", b_o, 32'd0);
        check("async_dest", dest_o, 5'd0);
        check("async_count", cnt_o, 16'd0);
        check("async_in_ready", in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(5'd5, 5'd0, 1'b0, 16'h0, 4'b0000, 5'd1);
        tick();
        check("post_reset_r5", a_o, 32'd0);
        check("post_reset_valid", out_valid, 1'b1);
        check("post_reset_count", cnt_o, 16'd1);

        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (65535) tick();
        check("count_ffff", cnt_o, 16'hFFFF);
        tick();
        check("count_wrap", cnt_o, 16'h0000);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
